// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one iterative val/rdy multiplier among NREQ requesters.
// One operation in flight; the product is routed back to the requester that issued it.

module mul_share_lane #(
    parameter int IW  = 2,
    parameter int IDX = 0
) (
    input  logic [IW-1:0] grant,
    input  logic [IW-1:0] owner,
    input  logic          grant_en,
    input  logic          resp_en,
    output logic          req_rdy,
    output logic          resp_val
);
    assign req_rdy  = grant_en && (grant == IW'(IDX));
    assign resp_val = resp_en && (owner == IW'(IDX));
endmodule

module mul_share_arbiter #(
    parameter int N    = 6,
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   resp_val,
    input  logic [NREQ-1:0]   resp_rdy,
    output logic [N-1:0]      resp_c,
    output logic              mul_recv_val,
    input  logic              mul_recv_rdy,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic              mul_send_val,
    output logic              mul_send_rdy,
    input  logic [N-1:0]      mul_c,
    output logic              busy,
    output logic [IW-1:0]     owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, g, idx;
    logic          any, accept, grant_en, resp_en;
    logic [N-1:0]  a_r, b_r, c_r;

    // Scan downward so the index closest to ptr is the last (winning) assignment.
    always_comb begin
        g   = '0;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req_val[idx]) begin
                g   = idx;
                any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b1;
        accept       = 1'b0;
        mul_recv_val = 1'b0;
        mul_send_rdy = 1'b0;
        resp_en      = 1'b0;
        case (state)
            IDLE: begin
                busy   = 1'b0;
                accept = any;
                if (any) state_nx = ISSUE;
            end
            ISSUE: begin
                mul_recv_val = 1'b1;
                if (mul_recv_rdy) state_nx = WAIT;
            end
            WAIT: begin
                mul_send_rdy = 1'b1;
                if (mul_send_val) state_nx = RESP;
            end
            RESP: begin
                resp_en = 1'b1;
                if (resp_rdy[owner]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // req_rdy is combinational from req_val; gate it so it reads 0 while held in reset.
    assign grant_en = accept && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            owner <= '0;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
        end else begin
            if (accept) begin
                a_r   <= req_a[g*N +: N];
                b_r   <= req_b[g*N +: N];
                owner <= g;
                ptr   <= IW'((int'(g) + 1) % NREQ);
            end
            if (state == WAIT && mul_send_val) c_r <= mul_c;
        end
    end

    assign mul_a  = a_r;
    assign mul_b  = b_r;
    assign resp_c = c_r;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        mul_share_lane #(.IW(IW), .IDX(i)) u_lane (
            .grant    (g),
            .owner    (owner),
            .grant_en (grant_en),
            .resp_en  (resp_en),
            .req_rdy  (req_rdy[i]),
            .resp_val (resp_val[i])
        );
    end
endmodule
